// File: rtl/lsu_pkg.sv
// Shared KISC-V definitions for the load/store path: funct3 codes, opcodes,
// LSU state encodings and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // True when the op must be answered with an error and never reach the bus.
  function automatic logic req_bad(input logic store, input logic [2:0] f3,
                                   input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data extraction: picks the addressed byte/halfword from a bus word and
// sign- or zero-extends it according to funct3.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request over a
// valid/ready bus, with lane steering, strobes, load extension and error checks.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUS   | mem_valid high, outputs held until mem_ready
// RESP  | one-cycle resp_valid pulse to writeback
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [31:0] load_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        bad;

  assign req_ready = (state == IDLE);
  assign bad       = req_bad(req_store, req_funct3, req_addr[1:0]);

  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_funct3)
      F3_B: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      F3_H: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  lsu_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_lo_q  <= 2'd0;
      funct3_q   <= 3'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            funct3_q  <= req_funct3;
            mem_we    <= req_store;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= req_store ? st_wstrb : 4'd0;
            mem_wdata <= req_store ? st_wdata : 32'd0;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state     <= BUS;
              mem_valid <= 1'b1;
            end
          end
        end
        BUS: begin
          if (mem_ready) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_we ? 32'd0 : load_data;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed loads, stores, errors, wait states
// and reset during a bus transfer.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata);
    chk({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
    chk({tag, ".mem_we"},    {31'd0, mem_we}, {31'd0, we});
    chk({tag, ".mem_addr"},  mem_addr, addr);
    chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic issue(input logic store, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata);
    @(negedge clk);
    chk("idle.req_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_rdata  = rdata;
    mem_ready  = 1'b0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5555_5555;
  endtask

  task automatic run_op(input string tag, input logic store, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    issue(store, f3, addr, wdata, rdata);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk_bus({tag, ".wait"}, store, exp_addr, exp_strb, exp_wdata);
    end
    @(negedge clk);
    chk_bus(tag, store, exp_addr, exp_strb, exp_wdata);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, ".resp_err"},   {31'd0, resp_err}, 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".mem_valid_off"}, {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_err(input string tag, input logic store, input logic [2:0] f3,
                         input logic [31:0] addr);
    issue(store, f3, addr, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, ".resp_err"},   {31'd0, resp_err}, 32'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".mem_valid"},  {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".mem_valid2"}, {31'd0, mem_valid}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst.req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err",   {31'd0, resp_err}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_valid",  {31'd0, mem_valid}, 32'd0);
    chk("rst.mem_we",     {31'd0, mem_we}, 32'd0);
    chk("rst.mem_addr",   mem_addr, 32'd0);
    chk("rst.mem_wstrb",  {28'd0, mem_wstrb}, 32'd0);
    chk("rst.mem_wdata",  mem_wdata, 32'd0);
    rst_n = 1'b1;

    run_op("lw",  1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'd0, 32'hDEADBEEF);
    run_op("lb",  1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFFFF80);
    run_op("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'd0, 32'h00000080);
    run_op("lh",  1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFF80FF);
    run_op("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'd0, 32'h000080FF);
    run_op("lb2", 1'b0, 3'b000, 32'h102, 32'd0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFFFFFF);
    run_op("lh0", 1'b0, 3'b001, 32'h100, 32'd0, 32'h12348765, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFF8765);
    run_op("sb",  1'b1, 3'b000, 32'h201, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h200, 4'b0010, 32'hABABABAB, 32'd0);
    run_op("sb3", 1'b1, 3'b000, 32'h203, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h200, 4'b1000, 32'hABABABAB, 32'd0);
    run_op("sh",  1'b1, 3'b001, 32'h202, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h200, 4'b1100, 32'h56AB56AB, 32'd0);
    run_op("sh0", 1'b1, 3'b001, 32'h204, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h204, 4'b0011, 32'h56AB56AB, 32'd0);
    run_op("sw5", 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 5, 32'h300, 4'b1111, 32'hCAFEF00D, 32'd0);
    run_op("lw2", 1'b0, 3'b010, 32'h404, 32'd0, 32'h0BADF00D, 2, 32'h404, 4'b0000, 32'd0, 32'h0BADF00D);

    run_err("lw_mis",  1'b0, 3'b010, 32'h102);
    run_err("sh_mis",  1'b1, 3'b001, 32'h101);
    run_err("lh_mis",  1'b0, 3'b101, 32'h103);
    run_err("ld_ill",  1'b0, 3'b011, 32'h100);
    run_err("st_ill",  1'b1, 3'b100, 32'h100);

    // reset while a load waits on the bus
    issue(1'b0, 3'b010, 32'h500, 32'd0, 32'h11112222);
    @(negedge clk);
    chk("rstbus.mem_valid_pre", {31'd0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstbus.mem_valid",  {31'd0, mem_valid}, 32'd0);
    chk("rstbus.req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rstbus.resp_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstbus.resp_valid2", {31'd0, resp_valid}, 32'd0);
    run_op("lw_after", 1'b0, 3'b010, 32'h600, 32'd0, 32'h87654321, 0, 32'h600, 4'b0000, 32'd0, 32'h87654321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
